// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_unit
//  Brief    : Instruction fetch stage. Direct-mapped single-word icache,
//             static/BHT next-PC prediction, ROB rollback redirect.
//             Optional feature macro: IFETCH_BHT_EN (2-bit counter BHT).
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_unit #(
    parameter int ICACHE_INDEX_BITS = 4,
    parameter int BHT_INDEX_BITS    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data,
    input  logic        br_update_valid,
    input  logic [31:0] br_update_pc,
    input  logic        br_taken,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_predict_jump
);

    localparam int         c_lines      = 1 << ICACHE_INDEX_BITS;
    localparam int         c_tag_w      = 32 - ICACHE_INDEX_BITS - 2;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;

    typedef enum logic [0:0] {
        S_FETCH    = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        pred_q, pred_d;
    logic        mc_req_q, mc_req_d;
    logic [31:0] mc_addr_q, mc_addr_d;

    logic [c_lines-1:0] valid_q;
    logic [c_tag_w-1:0] tag_q  [c_lines];
    logic [31:0]        data_q [c_lines];

    logic [ICACHE_INDEX_BITS-1:0] w_idx;
    logic [ICACHE_INDEX_BITS-1:0] w_fill_idx;
    logic [c_tag_w-1:0]           w_tag;
    logic                         w_hit;
    logic [31:0]                  w_line;
    logic [6:0]                   w_opcode;
    logic [31:0]                  w_imm_j;
    logic [31:0]                  w_imm_b;
    logic                         w_br_pred;
    logic                         w_pred;
    logic [31:0]                  w_next_pc;
    logic                         w_fill_we;

    assign w_idx      = pc_q[ICACHE_INDEX_BITS+1:2];
    assign w_tag      = pc_q[31:ICACHE_INDEX_BITS+2];
    assign w_fill_idx = mc_addr_q[ICACHE_INDEX_BITS+1:2];
    assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_line     = data_q[w_idx];
    assign w_opcode   = w_line[6:0];

    assign w_imm_j = {{11{w_line[31]}}, w_line[31], w_line[19:12], w_line[20],
                      w_line[30:21], 1'b0};
    assign w_imm_b = {{19{w_line[31]}}, w_line[31], w_line[7], w_line[30:25],
                      w_line[11:8], 1'b0};

`ifdef IFETCH_BHT_EN
    localparam int c_bht_entries = 1 << BHT_INDEX_BITS;

    logic [1:0]                bht_q [c_bht_entries];
    logic [BHT_INDEX_BITS-1:0] w_bht_rd_idx;
    logic [BHT_INDEX_BITS-1:0] w_bht_wr_idx;
    logic                      unused_bht_bits;

    assign w_bht_rd_idx    = pc_q[BHT_INDEX_BITS+1:2];
    assign w_bht_wr_idx    = br_update_pc[BHT_INDEX_BITS+1:2];
    assign w_br_pred       = bht_q[w_bht_rd_idx][1];
    assign unused_bht_bits = ^{br_update_pc[31:BHT_INDEX_BITS+2], br_update_pc[1:0]};

    // Lookup reads the pre-update counter when both touch the same entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_bht_entries; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rdy && br_update_valid) begin
            if (br_taken) begin
                if (bht_q[w_bht_wr_idx] != 2'b11) begin
                    bht_q[w_bht_wr_idx] <= bht_q[w_bht_wr_idx] + 2'd1;
                end
            end else if (bht_q[w_bht_wr_idx] != 2'b00) begin
                bht_q[w_bht_wr_idx] <= bht_q[w_bht_wr_idx] - 2'd1;
            end
        end
    end
`else
    logic [BHT_INDEX_BITS-1:0] unused_bht_idx;
    logic                      unused_br;

    // Static rule: backward conditional branches are predicted taken.
    assign w_br_pred      = w_line[31];
    assign unused_bht_idx = br_update_pc[BHT_INDEX_BITS+1:2];
    assign unused_br      = ^{br_update_valid, br_taken, br_update_pc};
`endif

    always_comb begin
        w_pred    = 1'b0;
        w_next_pc = pc_q + 32'd4;
        if (w_opcode == c_opc_jal) begin
            w_pred    = 1'b1;
            w_next_pc = pc_q + w_imm_j;
        end else if ((w_opcode == c_opc_branch) && w_br_pred) begin
            w_pred    = 1'b1;
            w_next_pc = pc_q + w_imm_b;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        pred_d       = pred_q;
        mc_req_d     = mc_req_q;
        mc_addr_d    = mc_addr_q;
        w_fill_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (rollback) begin
                    pc_d = rollback_pc;
                end else if (w_hit) begin
                    if (!stall) begin
                        inst_valid_d = 1'b1;
                        inst_d       = w_line;
                        inst_pc_d    = pc_q;
                        pred_d       = w_pred;
                        pc_d         = w_next_pc;
                    end
                end else begin
                    mc_req_d  = 1'b1;
                    mc_addr_d = pc_q;
                    state_d   = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                // An in-flight read cannot be cancelled; its fill is still valid.
                if (mc_done) begin
                    w_fill_we = 1'b1;
                    mc_req_d  = 1'b0;
                    state_d   = S_FETCH;
                end
                if (rollback) begin
                    pc_d = rollback_pc;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            pred_q       <= 1'b0;
            mc_req_q     <= 1'b0;
            mc_addr_q    <= 32'd0;
            valid_q      <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            pred_q       <= pred_d;
            mc_req_q     <= mc_req_d;
            mc_addr_q    <= mc_addr_d;
            if (w_fill_we) begin
                valid_q[w_fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && rdy && w_fill_we) begin
            tag_q[w_fill_idx]  <= mc_addr_q[31:ICACHE_INDEX_BITS+2];
            data_q[w_fill_idx] <= mc_data;
        end
    end

    assign mc_req            = mc_req_q;
    assign mc_addr           = mc_addr_q;
    assign inst_valid        = inst_valid_q;
    assign inst              = inst_q;
    assign inst_pc           = inst_pc_q;
    assign inst_predict_jump = pred_q;

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder. Owns the PC and a direct-mapped single-word instruction cache, and refills misses through the memory controller.
- Makes a next-PC prediction for JAL and conditional branches.
- Emits at most one instruction per cycle as a one-cycle pulse (inst_valid, inst, inst_pc, inst_predict_jump). The decoder consumes this combinationally in the same cycle.
- Redirects on ROB rollback.

Parameters:
- ICACHE_INDEX_BITS, 4, log2 of icache lines (16 lines, one 32-bit word each).
- BHT_INDEX_BITS, 6, log2 of BHT entries (used only with IFETCH_BHT_EN).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset (rst==0 resets on the clk edge).
- rdy  input  1  global ready; when 0 all state freezes.
- stall  input  1  downstream full (ROB|RS|LSB); when 1, no instruction is issued.
- rollback  input  1  misprediction flush from the ROB.
- rollback_pc  input  32  correct PC to restart from.
- mc_req  output  1  instruction read request to the memory controller.
- mc_addr  output  32  word address of the request.
- mc_done  input  1  one-cycle pulse: mc_data is valid.
- mc_data  input  32  fetched instruction word.
- br_update_valid  input  1  branch resolved (from ROB commit).
- br_update_pc  input  32  PC of the resolved branch.
- br_taken  input  1  resolved direction.
- inst_valid  output  1  instruction pulse to the decoder.
- inst  output  32  instruction word.
- inst_pc  output  32  its PC.
- inst_predict_jump  output  1  1 = predicted taken.

Behaviour:
- Reset (rst==0 at the clk edge): pc=0, state=FETCH, inst_valid=0, inst=0, inst_pc=0, inst_predict_jump=0, mc_req=0, mc_addr=0, all cache valid bits=0, BHT counters=2'b01.
- rdy==0: no register changes, except that reset still applies.
- Outputs are registered. inst_valid is high for exactly one cycle per issued instruction and is 0 in every other cycle.
- Cache addressing:
  - index = pc[ICACHE_INDEX_BITS+1:2]
  - tag = pc[31:ICACHE_INDEX_BITS+2]
  - pc[1:0] is always 0.
- State FETCH, with !rollback:
  - Hit && !stall: on the next edge inst_valid=1, inst=line data, inst_pc=pc, inst_predict_jump=pred; pc <= next_pc. Latency from PC to decoder is 1 cycle, so back-to-back hits issue 1 instr/cycle.
  - Hit && stall: inst_valid=0, pc unchanged.
  - Miss (stall irrelevant): mc_req<=1, mc_addr<=pc, state<=WAIT_MEM, inst_valid=0.
- State WAIT_MEM:
  - mc_req stays 1 with mc_addr stable until mc_done.
  - On mc_done: write data/tag/valid at the mc_addr index, mc_req<=0, state<=FETCH.
  - The instruction is not forwarded; the next FETCH cycle hits. Miss penalty is memory latency + 1.
- Prediction (opcode = inst[6:0]):
  - JAL (1101111): taken; next_pc = pc + sext({i[31],i[19:12],i[20],i[30:21],0}).
  - Branch (1100011): taken iff the immediate sign bit i[31]==1 (backward); next_pc = pc + sext({i[31],i[7],i[30:25],i[11:8],0}).
  - JALR and all other opcodes: not taken; next_pc = pc+4.
  - All PC adds are modulo 2^32 (0xFFFFFFFC+4 = 0).
- Rollback (highest priority):
  - pc<=rollback_pc and inst_valid<=0 on that edge, regardless of stall or hit.
  - In WAIT_MEM the in-flight request cannot be aborted. Keep waiting; the fill on mc_done is still written (data is valid for its address), then FETCH resumes at the new pc.
  - rollback && mc_done in the same cycle: fill is written, state=FETCH, pc=rollback_pc.
- br_update_* is ignored unless IFETCH_BHT_EN is defined.

Optional Feature:
- Macro: IFETCH_BHT_EN.
- Defined:
  - 2^BHT_INDEX_BITS 2-bit saturating counters indexed by pc[BHT_INDEX_BITS+1:2].
  - A conditional branch is predicted taken iff counter >= 2.
  - On br_update_valid, the counter at br_update_pc's index increments (saturates at 3) if br_taken, else decrements (saturates at 0).
  - Update and lookup of the same index in one cycle: lookup sees the old value.
- Undefined: static backward-taken rule; br_update_* ports exist but are unused.

Test Plan:
- Reset, memory holds ADDI at 0x0 and 0x4, mc latency 3 -> mc_req with addr 0x0; after mc_done, inst_valid pulse with inst_pc=0x0; second miss at 0x4 follows; once cache is warm, hits are back-to-back with 1 instr/cycle.
- JAL x0,-8 at 0x10 (cached) -> inst_predict_jump=1, next inst_pc=0x08; BEQ with offset +12 at 0x20 -> predict 0, next inst_pc=0x24.
- stall=1 for 3 cycles during a hit stream -> inst_valid=0 for exactly those cycles; no PC skipped or duplicated after release.
- rollback with rollback_pc=0x100 while in WAIT_MEM for 0x40 -> mc_req stays until mc_done; line 0x40 is valid; next issued inst_pc=0x100.
- rollback coincident with mc_done and stall=1 -> no inst_valid that cycle; pc=rollback_pc; state=FETCH.
- IFETCH_BHT_EN: two br_taken=0 updates for a backward branch at 0x30 -> counter reaches 0, later fetch at 0x30 predicts 0; three taken updates -> predicts 1. rst=0 mid-miss -> mc_req=0, pc=0, all lines invalid.
